// File: rtl/bist_sw_led_if.sv
// bist_sw_led_if: BIST engine <-> board/DUT signal bundle
//   start      controller -> engine  1-cycle sweep request
//   dut_sw     engine -> DUT         applied input vector
//   dut_led    DUT -> engine         DUT response
//   busy       engine -> controller  sweep in progress
//   done       engine -> controller  1-cycle completion pulse
//   pass       engine -> controller  signature matched golden
//   signature  engine -> controller  current MISR contents
interface bist_sw_led_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 4
);
    logic             start;
    logic [IN_W-1:0]  dut_sw;
    logic [OUT_W-1:0] dut_led;
    logic             busy;
    logic             done;
    logic             pass;
    logic [OUT_W-1:0] signature;

    modport master (
        input  start, dut_led,
        output dut_sw, busy, done, pass, signature
    );

    modport slave (
        output start, dut_led,
        input  dut_sw, busy, done, pass, signature
    );
endinterface

// File: rtl/bist_sw_led.sv
// bist_sw_led: exhaustive sw sweep of a combinational DUT with MISR signature check
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bist   bist_sw_led_if.master: start in, dut_sw out, dut_led in,
//          busy/done/pass/signature out
module bist_sw_led #(
    parameter int               IN_W   = 4,
    parameter int               OUT_W  = 4,
    parameter int               SETTLE = 2,
    parameter logic [OUT_W-1:0] POLY   = 'h3,
    parameter logic [OUT_W-1:0] GOLDEN = 'hB
) (
    input  logic clk,
    input  logic rst_n,
    bist_sw_led_if.master bist
);
    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, FINISH} state_t;

    state_t           state_q, state_d;
    logic [IN_W-1:0]  sw_q, sw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0] sig_q, sig_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sw_q    <= '0;
            cnt_q   <= '0;
            sig_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sw_q    <= sw_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sw_d    = sw_q;
        cnt_d   = cnt_q;
        sig_d   = sig_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (bist.start) begin
                    state_d = HOLD;
                    sig_d   = '0;
                    sw_d    = '0;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == CW'(SETTLE)) state_d = SAMPLE;
                else cnt_d = cnt_q + CW'(1);
            end
            SAMPLE: begin
                // Shift-left MISR: the bit leaving the top feeds back through POLY
                sig_d = {sig_q[OUT_W-2:0], 1'b0} ^ (sig_q[OUT_W-1] ? POLY : '0) ^ bist.dut_led;
                // The all-ones vector is the last one; the counter never wraps
                if (&sw_q) begin
                    state_d = FINISH;
                end else begin
                    sw_d    = sw_q + IN_W'(1);
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (sig_q == GOLDEN);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bist.dut_sw    = sw_q;
    assign bist.busy      = busy_q;
    assign bist.done      = done_q;
    assign bist.pass      = pass_q;
    assign bist.signature = sig_q;
endmodule
